up_down_counter_param: RTL
==========================

Name: up_down_counter_param

Overview:
- Parametrised successor to the basic up/down counter.
- Adds configurable width, programmable step and modulo limit, synchronous load, enable, and a wrap/saturate mode.
- Reports boundary events through a terminal-count pulse and sticky overflow/underflow flags.
- Used as a general event/position counter under the existing interface-driven test environment.

Parameters:
WIDTH, 8, counter and limit width in bits (>=2)
STEP_W, 4, width of step input (STEP_W <= WIDTH)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
en  input  1  count enable; one step per enabled cycle
up  input  1  direction: 1 = increment, 0 = decrement
load  input  1  synchronous load request
load_val  input  WIDTH  value loaded when load=1
step  input  STEP_W  increment/decrement amount per enabled cycle
max_val  input  WIDTH  upper limit; legal count range is 0..max_val
mode  input  1  0 = wrap (modulo max_val+1), 1 = saturate
clear_flags  input  1  clears sticky flags
count  output  WIDTH  current count (registered)
at_max  output  1  combinational, count == max_val
at_min  output  1  combinational, count == 0
tc  output  1  registered one-cycle pulse on any boundary event
ovf_sticky  output  1  set on up-direction boundary event
unf_sticky  output  1  set on down-direction boundary event

Behaviour:
- Reset (rst=1 at edge): count=0, tc=0, ovf_sticky=0, unf_sticky=0. Resulting at_min=1 and at_max=(max_val==0). Reset overrides all other inputs, including mid-operation.
- Priority per edge: rst > load > range clamp > en. When en=0 and no higher-priority action applies, count holds and tc=0.
- Load: count <= min(load_val, max_val). Load produces no tc and no flag change.
- Range clamp: if count > max_val (max_val lowered at runtime), the next edge sets count <= max_val regardless of en. No tc, no flags.
- Arithmetic: performed in WIDTH+1 bits, no intermediate truncation. Requirement: step <= max_val+1. If this is violated in wrap mode, the result follows saturate rules.
- Up (en=1, up=1):
  - If count+step <= max_val: count <= count+step.
  - Else, wrap mode: count <= count+step-(max_val+1). Saturate mode: count <= max_val.
  - In both overflow cases it is a boundary event: tc=1 next cycle, ovf_sticky <= 1.
- Down (en=1, up=0):
  - If step <= count: count <= count-step.
  - Else, wrap mode: count <= count+(max_val+1)-step. Saturate mode: count <= 0.
  - In both underflow cases it is a boundary event: tc=1, unf_sticky <= 1.
- step=0 with en=1: count holds, no event.
- Saturate mode at a limit: continued stepping into the limit raises a boundary event each enabled cycle (tc re-pulses every cycle).
- tc: registered in the same edge as the boundary count update; high for exactly one cycle per event.
- Sticky flags:
  - clear_flags=1 clears both flags.
  - A boundary event in the same cycle as clear_flags wins: the matching flag reads 1 afterwards.
- Latency: one cycle from inputs to count/tc/flags. at_max/at_min follow count combinationally.

Optional Feature:
UDC_WRAP_COUNT_EN
- Defined: adds output port wrap_cnt (16 bits) counting boundary events.
  - Increments by 1 per event and saturates at 0xFFFF.
  - Reset to 0 by rst or clear_flags. An event coinciding with clear_flags yields wrap_cnt=1.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
1. Reset: rst=1 for 2 cycles with en=1, up=1 -> count=0x00, tc=0, flags=0, at_min=1. Release rst -> counting starts on the next edge.
2. Up wrap: max_val=9, step=1, mode=0, 10 enabled cycles from 0 -> count 1..9 then 0. tc high only in the cycle count=0; ovf_sticky=1; at_max=1 while count=9.
3. Down wrap with step: max_val=9, load 1, step=3, mode=0, up=0, one enabled cycle -> count=8, tc=1, unf_sticky=1, ovf_sticky unchanged.
4. Down saturate: max_val=20, load 3, step=2, mode=1, up=0, 3 enabled cycles -> count 1, 0, 0. tc pulses on the 2nd and 3rd cycles; unf_sticky=1.
5. Load priority and clamp: max_val=99, load=1, en=1, load_val=200 -> count=99, tc=0. Then max_val=50 with en=0 -> count=50 next edge.
6. Flags and reset mid-op: with ovf_sticky=1, assert clear_flags plus an up-wrap event in the same cycle -> ovf_sticky stays 1. Then rst=1 during counting -> count=0, all flags 0 next edge. With UDC_WRAP_COUNT_EN defined, wrap_cnt=0 after reset.

Source files
------------

// File: rtl/udc_if.sv
// Bus for up_down_counter_param: control/config inputs and count/status outputs.
// With UDC_WRAP_COUNT_EN defined the bus also carries the 16-bit wrap_cnt.
interface udc_if #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STEP_W = 4
);
    logic              en;
    logic              up;
    logic              load;
    logic [WIDTH-1:0]  load_val;
    logic [STEP_W-1:0] step;
    logic [WIDTH-1:0]  max_val;
    logic              mode;
    logic              clear_flags;
    logic [WIDTH-1:0]  count;
    logic              at_max;
    logic              at_min;
    logic              tc;
    logic              ovf_sticky;
    logic              unf_sticky;
`ifdef UDC_WRAP_COUNT_EN
    logic [15:0]       wrap_cnt;
`endif

`ifdef UDC_WRAP_COUNT_EN
    modport master (
        output en, up, load, load_val, step, max_val, mode, clear_flags,
        input  count, at_max, at_min, tc, ovf_sticky, unf_sticky, wrap_cnt
    );
    modport slave (
        input  en, up, load, load_val, step, max_val, mode, clear_flags,
        output count, at_max, at_min, tc, ovf_sticky, unf_sticky, wrap_cnt
    );
`else
    modport master (
        output en, up, load, load_val, step, max_val, mode, clear_flags,
        input  count, at_max, at_min, tc, ovf_sticky, unf_sticky
    );
    modport slave (
        input  en, up, load, load_val, step, max_val, mode, clear_flags,
        output count, at_max, at_min, tc, ovf_sticky, unf_sticky
    );
`endif
endinterface

// File: rtl/up_down_counter_param.sv
// Parametrised up/down counter with step, modulo limit, wrap/saturate mode and boundary flags.
// Optional UDC_WRAP_COUNT_EN adds a saturating 16-bit boundary-event counter (wrap_cnt).
module up_down_counter_param #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STEP_W = 4
) (
    input  logic  clk,
    input  logic  rst,
    udc_if.slave  bus
);
    localparam int unsigned XW = WIDTH + 1;

    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic             r_ovf;
    logic             r_unf;

    logic [XW-1:0]    w_cnt_x;
    logic [XW-1:0]    w_step_x;
    logic [XW-1:0]    w_max_x;
    logic [XW-1:0]    w_lim_x;
    logic [XW-1:0]    w_sum_x;
    logic [WIDTH-1:0] w_next;
    logic             w_wrap_ok;
    logic             w_clamp;
    logic             w_do_step;
    logic             w_evt_up;
    logic             w_evt_dn;
    logic             w_evt;

    assign w_cnt_x   = XW'(r_count);
    assign w_step_x  = XW'(bus.step);
    assign w_max_x   = XW'(bus.max_val);
    assign w_lim_x   = w_max_x + XW'(1);
    assign w_sum_x   = w_cnt_x + w_step_x;
    assign w_clamp   = (r_count > bus.max_val);
    assign w_do_step = bus.en & ~bus.load & ~w_clamp;
    // An oversized step cannot wrap cleanly, so it falls back to saturation
    assign w_wrap_ok = ~bus.mode & (w_step_x <= w_lim_x);

    // Next count for an enabled step, plus boundary-event detection
    always_comb begin
        w_next   = r_count;
        w_evt_up = 1'b0;
        w_evt_dn = 1'b0;
        if (bus.up) begin
            if (w_sum_x <= w_max_x) begin
                w_next = WIDTH'(w_sum_x);
            end else begin
                w_evt_up = w_do_step;
                w_next   = w_wrap_ok ? WIDTH'(w_sum_x - w_lim_x) : bus.max_val;
            end
        end else begin
            if (w_step_x <= w_cnt_x) begin
                w_next = WIDTH'(w_cnt_x - w_step_x);
            end else begin
                w_evt_dn = w_do_step;
                w_next   = w_wrap_ok ? WIDTH'(w_cnt_x + w_lim_x - w_step_x) : '0;
            end
        end
    end

    assign w_evt = w_evt_up | w_evt_dn;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_tc    <= 1'b0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            if (bus.load) begin
                r_count <= (bus.load_val > bus.max_val) ? bus.max_val : bus.load_val;
            end else if (w_clamp) begin
                r_count <= bus.max_val;
            end else if (bus.en) begin
                r_count <= w_next;
            end
            r_tc  <= w_evt;
            // Event wins over a coincident clear
            r_ovf <= (r_ovf & ~bus.clear_flags) | w_evt_up;
            r_unf <= (r_unf & ~bus.clear_flags) | w_evt_dn;
        end
    end

`ifdef UDC_WRAP_COUNT_EN
    logic [15:0] r_wrap_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrap_cnt <= '0;
        end else if (bus.clear_flags) begin
            r_wrap_cnt <= 16'(w_evt);
        end else if (w_evt && (r_wrap_cnt != 16'hFFFF)) begin
            r_wrap_cnt <= r_wrap_cnt + 16'd1;
        end
    end

    assign bus.wrap_cnt = r_wrap_cnt;
`endif

    assign bus.count      = r_count;
    assign bus.at_max     = (r_count == bus.max_val);
    assign bus.at_min     = (r_count == '0);
    assign bus.tc         = r_tc;
    assign bus.ovf_sticky = r_ovf;
    assign bus.unf_sticky = r_unf;
endmodule
